// File: rtl/fc_sequencer.sv
// fc_sequencer: loads FC weights/biases, then per frame issues vsync, streams features and returns the argmax.
// Optional macro FC_TIMEOUT_EN bounds the wait for the FC result and recovers through FC_RST.
module fc_sequencer #(
  parameter int WIDTH_D     = 27,
  parameter int WIDTH_P     = 60,
  parameter int SIZE_I      = 512,
  parameter int SIZE_O      = 1000,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               i_sclk,
  input  logic               i_rstn,
  input  logic               i_cfg_start,
  input  logic               s_param_valid,
  output logic               s_param_ready,
  input  logic [WIDTH_P-1:0] s_param_data,
  input  logic               s_param_last,
  input  logic               s_feat_valid,
  output logic               s_feat_ready,
  input  logic [WIDTH_D-1:0] s_feat_data,
  input  logic               s_feat_last,
  output logic               o_fc_rstp,
  output logic               o_fc_vsync,
  output logic               o_fc_valid,
  output logic [WIDTH_D-1:0] o_fc_tdata,
  output logic [1:0]         o_fc_param_vld,
  output logic [WIDTH_P-1:0] o_fc_param,
  input  logic               i_fc_predict_vld,
  input  logic [9:0]         i_fc_predict,
  output logic               o_result_vld,
  output logic [9:0]         o_result,
  output logic               o_loaded,
  output logic               o_busy,
  output logic [2:0]         o_err
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FC_RST    = 3'd1;
  localparam logic [2:0] ST_LOAD_W    = 3'd2;
  localparam logic [2:0] ST_LOAD_B    = 3'd3;
  localparam logic [2:0] ST_READY     = 3'd4;
  localparam logic [2:0] ST_VSYNC     = 3'd5;
  localparam logic [2:0] ST_STREAM    = 3'd6;
  localparam logic [2:0] ST_WAIT_PRED = 3'd7;

  // One beat counter serves every state; the timeout reuses it since the stream count is idle then.
  localparam int NUM_W   = SIZE_I * SIZE_O;
  localparam int CNT_MAX = (NUM_W > TIMEOUT_CYC) ? NUM_W : TIMEOUT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] W_LAST = CW'(NUM_W - 1);
  localparam logic [CW-1:0] B_LAST = CW'(SIZE_O - 1);
  localparam logic [CW-1:0] F_LAST = CW'(SIZE_I - 1);
  localparam logic [CW-1:0] R_LAST = CW'(1);
`ifdef FC_TIMEOUT_EN
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYC - 1);
`endif

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               reload_q, reload_d;
  logic               loaded_q, loaded_d;
  logic [2:0]         err_q, err_d;
  logic [1:0]         param_vld_q, param_vld_d;
  logic [WIDTH_P-1:0] param_q, param_d;
  logic               fc_valid_q, fc_valid_d;
  logic [WIDTH_D-1:0] tdata_q, tdata_d;
  logic [9:0]         result_q, result_d;
  logic               result_vld_q, result_vld_d;

  logic p_hs;
  logic f_hs;
  logic start_acc;

  // Ready/strobe decodes come from the state register only, never from the valids.
  assign s_param_ready = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_B);
  assign s_feat_ready  = (state_q == ST_STREAM);
  assign o_fc_rstp     = (state_q == ST_IDLE) || (state_q == ST_FC_RST);
  assign o_fc_vsync    = (state_q == ST_VSYNC);
  assign o_busy        = (state_q != ST_IDLE) && (state_q != ST_READY);

  assign p_hs      = s_param_valid && s_param_ready;
  assign f_hs      = s_feat_valid && s_feat_ready;
  assign start_acc = i_cfg_start && ((state_q == ST_IDLE) || (state_q == ST_READY));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    reload_d     = reload_q;
    loaded_d     = loaded_q;
    err_d        = err_q;
    param_vld_d  = '0;
    param_d      = '0;
    fc_valid_d   = 1'b0;
    tdata_d      = '0;
    result_d     = result_q;
    result_vld_d = 1'b0;

    if (start_acc) begin
      state_d  = ST_FC_RST;
      cnt_d    = '0;
      reload_d = 1'b1;
      loaded_d = 1'b0;
      err_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_FC_RST: begin
          if (cnt_q == R_LAST) begin
            cnt_d   = '0;
            state_d = reload_q ? ST_LOAD_W : ST_READY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_LOAD_W: begin
          if (p_hs) begin
            param_vld_d = 2'b01;
            param_d     = s_param_data;
            if (s_param_last) err_d[0] = 1'b1;
            if (cnt_q == W_LAST) begin
              cnt_d   = '0;
              state_d = ST_LOAD_B;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ST_LOAD_B: begin
          if (p_hs) begin
            param_vld_d = 2'b10;
            param_d     = s_param_data;
            if (s_param_last != (cnt_q == B_LAST)) err_d[0] = 1'b1;
            if (cnt_q == B_LAST) begin
              cnt_d    = '0;
              loaded_d = 1'b1;
              state_d  = ST_READY;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ST_READY: begin
          if (s_feat_valid) state_d = ST_VSYNC;
        end
        ST_VSYNC: begin
          cnt_d   = '0;
          state_d = ST_STREAM;
        end
        ST_STREAM: begin
          if (f_hs) begin
            fc_valid_d = 1'b1;
            tdata_d    = s_feat_data;
            if (s_feat_last != (cnt_q == F_LAST)) err_d[1] = 1'b1;
            if (cnt_q == F_LAST) begin
              cnt_d   = '0;
              state_d = ST_WAIT_PRED;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        ST_WAIT_PRED: begin
          if (i_fc_predict_vld) begin
            result_d     = i_fc_predict;
            result_vld_d = 1'b1;
            cnt_d        = '0;
            state_d      = ST_READY;
          end
`ifdef FC_TIMEOUT_EN
          else if (cnt_q == T_LAST) begin
            err_d[2] = 1'b1;
            cnt_d    = '0;
            reload_d = 1'b0;
            state_d  = ST_FC_RST;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      reload_q     <= 1'b0;
      loaded_q     <= 1'b0;
      err_q        <= '0;
      param_vld_q  <= '0;
      param_q      <= '0;
      fc_valid_q   <= 1'b0;
      tdata_q      <= '0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reload_q     <= reload_d;
      loaded_q     <= loaded_d;
      err_q        <= err_d;
      param_vld_q  <= param_vld_d;
      param_q      <= param_d;
      fc_valid_q   <= fc_valid_d;
      tdata_q      <= tdata_d;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
    end
  end

  assign o_fc_param_vld = param_vld_q;
  assign o_fc_param     = param_q;
  assign o_fc_valid     = fc_valid_q;
  assign o_fc_tdata     = tdata_q;
  assign o_result       = result_q;
  assign o_result_vld   = result_vld_q;
  assign o_loaded       = loaded_q;
  assign o_err          = err_q;

endmodule
